// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10G PHY RX link controller: aligner reset/relock sequencing, sync-header BER monitor,
// link status and management counters.
module eth_phy_10g_rx_link_ctrl #(
  parameter int HDR_WIDTH     = 2,
  parameter int BER_WINDOW    = 19531,
  parameter int BER_THRESH    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int RST_HOLD      = 16,
  parameter int STATUS_DELAY  = 125,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_rx_block_lock,
  input  logic [HDR_WIDTH-1:0]     i_serdes_rx_hdr,
  input  logic                     i_err_clr,
  input  logic                     i_force_realign,
  output logic                     o_aligner_rst,
  output logic                     o_rx_status,
  output logic                     o_rx_hi_ber,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count,
  output logic [7:0]               o_retry_count,
  output logic [2:0]               o_state
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int CLN_W  = $clog2(STATUS_DELAY + 1);
  localparam int WIN_W  = $clog2(BER_WINDOW);
  localparam int INV_W  = $clog2(BER_THRESH + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [CLN_W-1:0]  CLN_LAST  = CLN_W'(STATUS_DELAY - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(BER_WINDOW - 1);
  localparam logic [INV_W-1:0]  INV_MAX   = INV_W'(BER_THRESH);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_CHECK     = 3'd2,
    ST_UP        = 3'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [CLN_W-1:0]         clean_q, clean_d;
  logic [7:0]               retry_q, retry_d;
  logic [WIN_W-1:0]         win_q, win_d;
  logic [INV_W-1:0]         inv_q, inv_d, inv_sum;
  logic                     hi_ber_q, hi_ber_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic                     aligner_rst_q, status_q;
  logic                     inv_hdr, clean_cyc;

  // BER monitor and error counter
  always_comb begin
    inv_hdr  = i_rx_block_lock &&
               ((i_serdes_rx_hdr == '0) || (i_serdes_rx_hdr == '1));
    inv_sum  = (inv_hdr && (inv_q != INV_MAX)) ? inv_q + 1'b1 : inv_q;
    win_d    = '0;
    inv_d    = '0;
    hi_ber_d = 1'b0;
    if (i_rx_block_lock) begin
      if (win_q == WIN_LAST) begin
        hi_ber_d = (inv_sum == INV_MAX);
      end else begin
        win_d    = win_q + 1'b1;
        inv_d    = inv_sum;
        hi_ber_d = hi_ber_q || (inv_sum == INV_MAX);
      end
    end

    err_d = err_q;
    if (i_err_clr) begin
      err_d = inv_hdr ? ERR_CNT_WIDTH'(1) : '0;
    end else if (inv_hdr && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  // A locked cycle is clean only if hi_ber is low both before and after this edge,
  // so CHECK never promotes to UP on the edge where hi_ber rises.
  assign clean_cyc = i_rx_block_lock && !hi_ber_q && !hi_ber_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    clean_d = clean_q;
    retry_d = retry_q;
    if (i_force_realign) begin
      state_d = ST_RESET;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            tmo_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (i_rx_block_lock) begin
            state_d = ST_CHECK;
            clean_d = '0;
          end else if (tmo_q == TMO_LAST) begin
            state_d = ST_RESET;
            hold_d  = '0;
            if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (!i_rx_block_lock) begin
            state_d = ST_WAIT_LOCK;
            tmo_d   = '0;
          end else if (!clean_cyc) begin
            clean_d = '0;
          end else if (clean_q == CLN_LAST) begin
            state_d = ST_UP;
          end else begin
            clean_d = clean_q + 1'b1;
          end
        end
        ST_UP: begin
          if (!i_rx_block_lock) begin
            state_d = ST_WAIT_LOCK;
            tmo_d   = '0;
          end else if (hi_ber_d) begin
            state_d = ST_CHECK;
            clean_d = '0;
          end
        end
        default: begin
          state_d = ST_RESET;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q       <= ST_RESET;
      hold_q        <= '0;
      tmo_q         <= '0;
      clean_q       <= '0;
      retry_q       <= '0;
      win_q         <= '0;
      inv_q         <= '0;
      hi_ber_q      <= 1'b0;
      err_q         <= '0;
      aligner_rst_q <= 1'b1;
      status_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      tmo_q         <= tmo_d;
      clean_q       <= clean_d;
      retry_q       <= retry_d;
      win_q         <= win_d;
      inv_q         <= inv_d;
      hi_ber_q      <= hi_ber_d;
      err_q         <= err_d;
      aligner_rst_q <= (state_d == ST_RESET);
      status_q      <= (state_d == ST_UP);
    end
  end

  assign o_aligner_rst = aligner_rst_q;
  assign o_rx_status   = status_q;
  assign o_rx_hi_ber   = hi_ber_q;
  assign o_err_count   = err_q;
  assign o_retry_count = retry_q;
  assign o_state       = state_q;

endmodule
